// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/LSU arbiter for a shared single-port memory
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        cpu_wait
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] LAT_END    = 3'(MEM_LAT);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [2:0]  lat_q, lat_d;
    logic [2:0]  starve_q, starve_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic        force_fetch;

    // owner_q: 1 = LSU transaction, 0 = fetch transaction
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        if_rvalid   = 1'b0;
        d_rvalid    = 1'b0;
        mem_req     = 1'b0;
        force_fetch = if_req && (starve_q == STARVE_LIM);

        case (state_q)
            IDLE: begin
                if (d_req && !force_fetch) begin
                    d_gnt   = 1'b1;
                    owner_d = 1'b1;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    lat_d   = 3'd0;
                    state_d = BUSY;
                    if (!if_req) begin
                        starve_d = 3'd0;
                    end else if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 3'd1;
                    end
                end else if (if_req) begin
                    if_gnt   = 1'b1;
                    owner_d  = 1'b0;
                    addr_d   = if_addr;
                    we_d     = 4'd0;
                    wdata_d  = 32'd0;
                    lat_d    = 3'd0;
                    starve_d = 3'd0;
                    state_d  = BUSY;
                end else begin
                    starve_d = 3'd0;
                end
            end
            BUSY: begin
                mem_req = (lat_q == 3'd0);
                lat_d   = lat_q + 3'd1;
                if (lat_q == LAT_END) begin
                    if_rvalid = ~owner_q;
                    d_rvalid  = owner_q;
                    lat_d     = 3'd0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset silences every strobe immediately, dropping any in-flight response
        if (rst) begin
            if_gnt    = 1'b0;
            d_gnt     = 1'b0;
            if_rvalid = 1'b0;
            d_rvalid  = 1'b0;
            mem_req   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            lat_q    <= 3'd0;
            starve_q <= 3'd0;
            addr_q   <= 32'd0;
            we_q     <= 4'd0;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = mem_req ? we_q : 4'd0;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign cpu_wait  = ~rst & ((if_req & ~if_rvalid) | (d_req & ~d_rvalid));

endmodule
